// File: rtl/aes_stream_pkg.sv
// Shared widths, FSM encoding and word-select helper for the AES ciphertext streamer.
package aes_stream_pkg;

   localparam int unsigned BLK_W         = 128;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned WORDS_PER_BLK = BLK_W / WORD_W;
   localparam int unsigned IDX_W         = $clog2(WORDS_PER_BLK);

   typedef enum logic {
      StIdle = 1'b0,
      StSend = 1'b1
   } state_e;

   // Word 0 is the most significant slice of the block.
   function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                  input logic [IDX_W-1:0] idx);
      logic [BLK_W-1:0] sh;
      sh = blk << (WORD_W * int'(idx));
      return sh[BLK_W-1 -: WORD_W];
   endfunction

endpackage

// File: rtl/cipher_blk_fifo.sv
// Block FIFO holding whole ciphertext blocks; separate count so full/empty are unambiguous.
module cipher_blk_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 128,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign push_ok = push_i && !flush_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !flush_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/cipher_word_streamer.sv
// Queues AES ciphertext blocks and streams them as MS-first 32-bit words over valid/ready.
module cipher_word_streamer
   import aes_stream_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              done_i,
   input  logic [BLK_W-1:0]  ciphertext_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   output logic              word_last_o,
   output logic [CntW-1:0]   fifo_count_o,
   output logic              overflow_o
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS_PER_BLK - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             overflow_q, overflow_d;

   logic             fifo_full, fifo_empty;
   logic [BLK_W-1:0] head_blk;
   logic [CntW-1:0]  fifo_count;
   logic             sending, handshake, last_hs, push, pop;

   assign sending   = (state_q == StSend);
   assign handshake = sending && word_ready_i;
   assign last_hs   = handshake && (idx_q == LastIdx);
   assign pop       = last_hs && !clear_i;
   // The final-word pop frees a slot in time for a same-cycle capture.
   assign push      = done_i && !clear_i && (!fifo_full || pop);

   cipher_blk_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BLK_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (clear_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (ciphertext_i),
      .rdata_o (head_blk),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      overflow_d = overflow_q;
      if (clear_i) begin
         state_d    = StIdle;
         idx_d      = '0;
         overflow_d = 1'b0;
      end else begin
         if (done_i && fifo_full && !pop) overflow_d = 1'b1;
         unique case (state_q)
            StIdle: begin
               idx_d = '0;
               if (!fifo_empty || push) state_d = StSend;
            end
            StSend: begin
               if (handshake) begin
                  if (idx_q == LastIdx) begin
                     idx_d   = '0;
                     state_d = ((fifo_count > CntW'(1)) || push) ? StSend : StIdle;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
      end
   end

   assign word_valid_o = sending;
   assign word_o       = sending ? word_sel(head_blk, idx_q) : '0;
   assign word_last_o  = sending && (idx_q == LastIdx);
   assign fifo_count_o = fifo_count;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_cipher_word_streamer.sv
// Directed bench for cipher_word_streamer: inputs driven and outputs sampled on the falling edge.
module tb_cipher_word_streamer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          clear_i;
   logic          done_i;
   logic [127:0]  ciphertext_i;
   logic [31:0]   word_o;
   logic          word_valid_o;
   logic          word_ready_i;
   logic          word_last_o;
   logic [CW-1:0] fifo_count_o;
   logic          overflow_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cipher_word_streamer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (clear_i),
      .done_i       (done_i),
      .ciphertext_i (ciphertext_i),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .word_ready_i (word_ready_i),
      .word_last_o  (word_last_o),
      .fifo_count_o (fifo_count_o),
      .overflow_o   (overflow_o)
   );

   // Block k carries words 0xk0, 0xk1, 0xk2, 0xk3 so order errors are visible.
   function automatic logic [127:0] blk(input int k);
      logic [31:0] b;
      b = 32'(k) << 4;
      return {b, b | 32'd1, b | 32'd2, b | 32'd3};
   endfunction

   function automatic logic [31:0] wd(input logic [127:0] b, input int i);
      logic [127:0] t;
      t = b >> (32 * (3 - i));
      return t[31:0];
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", word_valid_o); else n_pass++;
      n_checks++; if (word_o !== 32'h0) $display("FAIL reset_word: got %h expected 0", word_o); else n_pass++;
      n_checks++; if (word_last_o !== 1'b0) $display("FAIL reset_last: got %b expected 0", word_last_o); else n_pass++;
      n_checks++; if (fifo_count_o !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count_o); else n_pass++;
      n_checks++; if (overflow_o !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow_o); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL post_reset_valid: got %b expected 0", word_valid_o); else n_pass++;
   endtask

   task automatic test_single();
      logic [31:0] exp_w [4];
      exp_w = '{32'h8ea2b7ca, 32'h516745bf, 32'heafc4990, 32'h4b496089};
      ciphertext_i = 128'h8ea2b7ca516745bfeafc49904b496089;
      done_i = 1'b1;
      word_ready_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (word_valid_o !== 1'b1) $display("FAIL single_valid%0d: got %b expected 1", i, word_valid_o); else n_pass++;
         n_checks++; if (word_o !== exp_w[i]) $display("FAIL single_word%0d: got %h expected %h", i, word_o, exp_w[i]); else n_pass++;
         n_checks++; if (word_last_o !== (i == 3)) $display("FAIL single_last%0d: got %b expected %b", i, word_last_o, (i == 3)); else n_pass++;
         n_checks++; if (fifo_count_o !== 3'd1) $display("FAIL single_count%0d: got %0d expected 1", i, fifo_count_o); else n_pass++;
         @(negedge clk);
      end
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL single_idle_valid: got %b expected 0", word_valid_o); else n_pass++;
      n_checks++; if (fifo_count_o !== 3'd0) $display("FAIL single_idle_count: got %0d expected 0", fifo_count_o); else n_pass++;
   endtask

   task automatic test_stall();
      logic [127:0] b;
      logic         pat [7];
      int           hs;
      b   = 128'h8ea2b7ca516745bfeafc49904b496089;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      hs  = 0;
      ciphertext_i = b;
      done_i = 1'b1;
      word_ready_i = 1'b0;
      @(negedge clk);
      done_i = 1'b0;
      for (int k = 0; k < 7; k++) begin
         n_checks++; if (word_valid_o !== 1'b1) $display("FAIL stall_valid%0d: got %b expected 1", k, word_valid_o); else n_pass++;
         n_checks++; if (word_o !== wd(b, hs)) $display("FAIL stall_word%0d: got %h expected %h", k, word_o, wd(b, hs)); else n_pass++;
         n_checks++; if (word_last_o !== (hs == 3)) $display("FAIL stall_last%0d: got %b expected %b", k, word_last_o, (hs == 3)); else n_pass++;
         word_ready_i = pat[k];
         if (pat[k]) hs++;
         @(negedge clk);
      end
      word_ready_i = 1'b0;
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL stall_done_valid: got %b expected 0", word_valid_o); else n_pass++;
      n_checks++; if (fifo_count_o !== 3'd0) $display("FAIL stall_done_count: got %0d expected 0", fifo_count_o); else n_pass++;
   endtask

   task automatic test_overflow();
      word_ready_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         ciphertext_i = blk(k);
         done_i = 1'b1;
         @(negedge clk);
      end
      done_i = 1'b0;
      n_checks++; if (fifo_count_o !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", fifo_count_o); else n_pass++;
      n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow_o); else n_pass++;
      word_ready_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         for (int i = 0; i < 4; i++) begin
            n_checks++; if (word_valid_o !== 1'b1 || word_o !== wd(blk(k), i) || word_last_o !== (i == 3))
               $display("FAIL ovf_drain_b%0d_w%0d: got v=%b %h l=%b expected v=1 %h l=%b",
                        k, i, word_valid_o, word_o, word_last_o, wd(blk(k), i), (i == 3));
            else n_pass++;
            @(negedge clk);
         end
      end
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL ovf_no_block5: got valid %b word %h expected valid 0", word_valid_o, word_o); else n_pass++;
      n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow_o); else n_pass++;
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      n_checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_cleared: got %b expected 0", overflow_o); else n_pass++;
      word_ready_i = 1'b0;
   endtask

   task automatic test_full_pop_capture();
      word_ready_i = 1'b0;
      for (int k = 6; k <= 9; k++) begin
         ciphertext_i = blk(k);
         done_i = 1'b1;
         @(negedge clk);
      end
      done_i = 1'b0;
      n_checks++; if (fifo_count_o !== 3'd4) $display("FAIL fpc_full_count: got %0d expected 4", fifo_count_o); else n_pass++;
      word_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (word_o !== wd(blk(6), i)) $display("FAIL fpc_head_w%0d: got %h expected %h", i, word_o, wd(blk(6), i)); else n_pass++;
         if (i == 3) begin
            ciphertext_i = blk(10);
            done_i = 1'b1;
         end
         @(negedge clk);
         done_i = 1'b0;
      end
      n_checks++; if (fifo_count_o !== 3'd4) $display("FAIL fpc_count: got %0d expected 4", fifo_count_o); else n_pass++;
      n_checks++; if (overflow_o !== 1'b0) $display("FAIL fpc_overflow: got %b expected 0", overflow_o); else n_pass++;
      for (int k = 7; k <= 10; k++) begin
         for (int i = 0; i < 4; i++) begin
            n_checks++; if (word_valid_o !== 1'b1 || word_o !== wd(blk(k), i) || word_last_o !== (i == 3))
               $display("FAIL fpc_drain_b%0d_w%0d: got v=%b %h l=%b expected v=1 %h l=%b",
                        k, i, word_valid_o, word_o, word_last_o, wd(blk(k), i), (i == 3));
            else n_pass++;
            @(negedge clk);
         end
      end
      n_checks++; if (word_valid_o !== 1'b0 || fifo_count_o !== 3'd0)
         $display("FAIL fpc_empty: got valid %b count %0d expected 0 0", word_valid_o, fifo_count_o);
      else n_pass++;
      word_ready_i = 1'b0;
   endtask

   task automatic test_clear();
      word_ready_i = 1'b0;
      for (int k = 11; k <= 12; k++) begin
         ciphertext_i = blk(k);
         done_i = 1'b1;
         @(negedge clk);
      end
      done_i = 1'b0;
      n_checks++; if (fifo_count_o !== 3'd2) $display("FAIL clr_count_before: got %0d expected 2", fifo_count_o); else n_pass++;
      word_ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (word_o !== wd(blk(11), i)) $display("FAIL clr_pre_w%0d: got %h expected %h", i, word_o, wd(blk(11), i)); else n_pass++;
         @(negedge clk);
      end
      // Clear coincides with a capture strobe, which must be dropped.
      clear_i = 1'b1;
      done_i = 1'b1;
      ciphertext_i = blk(13);
      word_ready_i = 1'b0;
      @(negedge clk);
      clear_i = 1'b0;
      done_i = 1'b0;
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL clr_valid: got %b expected 0", word_valid_o); else n_pass++;
      n_checks++; if (fifo_count_o !== 3'd0) $display("FAIL clr_count: got %0d expected 0", fifo_count_o); else n_pass++;
      n_checks++; if (overflow_o !== 1'b0) $display("FAIL clr_overflow: got %b expected 0", overflow_o); else n_pass++;
      @(negedge clk);
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL clr_dropped: got valid %b expected 0", word_valid_o); else n_pass++;
      ciphertext_i = blk(14);
      done_i = 1'b1;
      word_ready_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (word_valid_o !== 1'b1 || word_o !== wd(blk(14), i) || word_last_o !== (i == 3))
            $display("FAIL clr_post_w%0d: got v=%b %h l=%b expected v=1 %h l=%b",
                     i, word_valid_o, word_o, word_last_o, wd(blk(14), i), (i == 3));
         else n_pass++;
         @(negedge clk);
      end
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL clr_post_idle: got %b expected 0", word_valid_o); else n_pass++;
      word_ready_i = 1'b0;
   endtask

   task automatic test_async_reset();
      ciphertext_i = blk(15);
      done_i = 1'b1;
      word_ready_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      n_checks++; if (word_o !== wd(blk(15), 0)) $display("FAIL arst_pre_w0: got %h expected %h", word_o, wd(blk(15), 0)); else n_pass++;
      @(negedge clk);
      n_checks++; if (word_o !== wd(blk(15), 1)) $display("FAIL arst_pre_w1: got %h expected %h", word_o, wd(blk(15), 1)); else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL arst_valid: got %b expected 0", word_valid_o); else n_pass++;
      n_checks++; if (word_o !== 32'h0) $display("FAIL arst_word: got %h expected 0", word_o); else n_pass++;
      n_checks++; if (word_last_o !== 1'b0) $display("FAIL arst_last: got %b expected 0", word_last_o); else n_pass++;
      n_checks++; if (fifo_count_o !== 3'd0) $display("FAIL arst_count: got %0d expected 0", fifo_count_o); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (word_valid_o !== 1'b0) $display("FAIL arst_release_valid: got %b expected 0", word_valid_o); else n_pass++;
      ciphertext_i = blk(16);
      done_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (word_valid_o !== 1'b1 || word_o !== wd(blk(16), i) || word_last_o !== (i == 3))
            $display("FAIL arst_post_w%0d: got v=%b %h l=%b expected v=1 %h l=%b",
                     i, word_valid_o, word_o, word_last_o, wd(blk(16), i), (i == 3));
         else n_pass++;
         @(negedge clk);
      end
      n_checks++; if (word_valid_o !== 1'b0 || fifo_count_o !== 3'd0)
         $display("FAIL arst_post_idle: got valid %b count %0d expected 0 0", word_valid_o, fifo_count_o);
      else n_pass++;
      word_ready_i = 1'b0;
   endtask

   initial begin
      rst          = 1'b0;
      clear_i      = 1'b0;
      done_i       = 1'b0;
      word_ready_i = 1'b0;
      ciphertext_i = '0;
      test_reset();
      test_single();
      test_stall();
      test_overflow();
      test_full_pop_capture();
      test_clear();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
